// File: rtl/vlsu_mem_responder.sv
// vlsu_mem_responder: serves VLSU element requests from a local word memory, returning index-tagged load data in accept order
module vlsu_mem_responder #(
    parameter int XLEN       = 32,
    parameter int IDXW       = 4,
    parameter int DEPTH      = 256,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [IDXW-1:0] req_idx,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_last,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDXW-1:0] rsp_idx,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    output logic            done,
    output logic            err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {ACCEPT, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [XLEN-1:0] data;
        logic            err;
    } rsp_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] mem [DEPTH];
    rsp_t            fifo [FIFO_DEPTH];
    rsp_t            ld_e, push_e, head;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d, fresh_q, fresh_d;
    logic            acc, in_range, ld_v, push_v, pop;
    int              pipe_n;

    assign in_range = req_addr < XLEN'(DEPTH);
    assign acc      = req_valid & req_ready;
    assign ld_v     = acc & ~req_we;
    assign ld_e     = '{idx: req_idx, data: in_range ? mem[req_addr[AW-1:0]] : '0, err: ~in_range};

    generate
        if (MEM_LAT == 1) begin : g_direct
            assign push_v = ld_v;
            assign push_e = ld_e;
            assign pipe_n = 0;
        end else begin : g_pipe
            logic [MEM_LAT-2:0] v_q;
            rsp_t               e_q [MEM_LAT-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int i = 0; i < MEM_LAT - 1; i++) e_q[i] <= '0;
                end else begin
                    v_q[0] <= ld_v;
                    e_q[0] <= ld_e;
                    for (int i = 1; i < MEM_LAT - 1; i++) begin
                        v_q[i] <= v_q[i-1];
                        e_q[i] <= e_q[i-1];
                    end
                end
            end
            assign push_v = v_q[MEM_LAT-2];
            assign push_e = e_q[MEM_LAT-2];
            assign pipe_n = $countones(v_q);
        end
    endgenerate

    assign head      = fifo[rd_q];
    assign rsp_valid = cnt_q != '0;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_idx   = rsp_valid ? head.idx : '0;
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_err   = rsp_valid & head.err;
    assign done      = state_q == DONE;
    assign err       = err_q;
    // Loads in the pipe already own a FIFO slot, so the pipe itself never has to stall.
    assign req_ready = rst_n && state_q == ACCEPT && int'(cnt_q) + pipe_n - int'(pop) < FIFO_DEPTH;

    always_comb begin
        wr_d    = wr_q + PW'(push_v);
        rd_d    = rd_q + PW'(pop);
        cnt_d   = cnt_q + CW'(push_v) - CW'(pop);
        state_d = state_q == ACCEPT ? (acc && req_last ? DRAIN : ACCEPT)
                : state_q == DRAIN  ? (pipe_n == 0 && cnt_d == '0 ? DONE : DRAIN)
                : ACCEPT;
        fresh_d = state_q == DONE ? 1'b1 : acc ? 1'b0 : fresh_q;
        err_d   = (acc & ~in_range) | (err_q & ~(acc & fresh_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCEPT;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fresh_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fresh_q <= fresh_d;
        end
    end

    // Storage arrays carry no reset: memory survives reset and FIFO slots are gated by cnt_q.
    always_ff @(posedge clk) begin
        if (acc && req_we && in_range) mem[req_addr[AW-1:0]] <= req_wdata;
        if (push_v) fifo[wr_q] <= push_e;
    end
endmodule

// File: tb/tb_vlsu_mem_responder.sv
// tb_vlsu_mem_responder: randomized stimulus checked against a queue-based reference model of the responder
module tb_vlsu_mem_responder;
    localparam int LAT = 2, FD = 4, DEPTH = 256;
    typedef struct { bit we; logic [31:0] addr; logic [3:0] idx; logic [31:0] wdata; bit last; } req_t;
    typedef struct { logic [3:0] idx; logic [31:0] data; bit err; int t; } rsp_t;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, req_last = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_idx = 0;
    logic        req_ready, rsp_valid, rsp_err, done, err;
    logic [3:0]  rsp_idx;
    logic [31:0] rsp_data;

    req_t        reqs[$];
    rsp_t        q[$];
    logic [31:0] mm [DEPTH];
    int          n_tests = 0, n_fail = 0, cyc = 0, rr_mode = 0;
    bit          bubbles = 0, draining = 0, exp_done = 0, exp_err = 0, fresh = 1;

    vlsu_mem_responder #(.XLEN(32), .IDXW(4), .DEPTH(DEPTH), .MEM_LAT(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_idx(req_idx), .req_wdata(req_wdata), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic add(input bit we, input logic [31:0] addr, input logic [3:0] idx,
                       input logic [31:0] wd, input bit last);
        reqs.push_back('{we, addr, idx, wd, last});
    endtask

    // One clock: drive at negedge, check, then advance the model at posedge by the spec's rules.
    task automatic tick();
        bit ev, er, ac, pp, was_draining, oor;
        if (reqs.size() > 0 && (!bubbles || $urandom_range(3) != 0)) begin
            req_valid = 1;
            req_we    = reqs[0].we;
            req_addr  = reqs[0].addr;
            req_idx   = reqs[0].idx;
            req_wdata = reqs[0].wdata;
            req_last  = reqs[0].last;
        end else begin
            req_valid = 0;
            req_we    = 1'($urandom_range(1));
            req_addr  = $urandom;
            req_last  = 1'($urandom_range(1));
        end
        rsp_ready = rr_mode == 0 ? 1'b1 : rr_mode == 2 ? 1'b0 : 1'($urandom_range(1));
        #1;
        ev = q.size() > 0 && q[0].t <= cyc;
        er = !draining && !exp_done && (q.size() - int'(ev && rsp_ready) < FD);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_idx", 32'(rsp_idx), 32'(q[0].idx));
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end
        chk("done", 32'(done), 32'(exp_done));
        chk("err", 32'(err), 32'(exp_err));
        ac = req_valid && er;
        pp = ev && rsp_ready;
        @(posedge clk);
        was_draining = draining;
        if (pp) void'(q.pop_front());
        if (exp_done) fresh = 1;
        if (ac) begin
            oor = req_addr >= DEPTH;
            if (fresh) exp_err = 0;
            fresh = 0;
            if (oor) exp_err = 1;
            if (req_we && !oor) mm[req_addr[7:0]] = req_wdata;
            if (!req_we) q.push_back('{req_idx, oor ? 32'h0 : mm[req_addr[7:0]], oor, cyc + LAT});
            if (req_last) draining = 1;
            void'(reqs.pop_front());
        end
        exp_done = was_draining && q.size() == 0;
        if (exp_done) draining = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_idle(input int budget);
        bit busy;
        while ((reqs.size() > 0 || q.size() > 0 || draining || exp_done) && budget > 0) begin
            tick();
            budget--;
        end
        busy = reqs.size() > 0 || q.size() > 0 || draining;
        chk("drain_timeout", 32'(busy), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) tick();
        for (int i = 0; i < 32; i++) add(1, i, 4'(i), $urandom, i == 31);
        run_idle(200);
        for (int i = 0; i < 4; i++) add(1, 10 + i, 4'(i), 32'hA0 + i, i == 3);
        run_idle(50);
        for (int i = 0; i < 4; i++) add(0, 10 + i, 4'(i), 0, i == 3);
        run_idle(50);
        add(1, 20, 0, 32'hDEAD, 0);
        add(0, 20, 1, 0, 1);
        run_idle(50);
        rr_mode = 2;
        for (int i = 0; i < 8; i++) add(0, i, 4'(i), 0, i == 7);
        repeat (12) tick();
        rr_mode = 0;
        run_idle(100);
        add(0, 300, 5, 0, 1);
        run_idle(50);
        add(0, 1, 0, 0, 1);
        run_idle(50);
        add(1, 5, 0, 32'h55, 0);
        add(1, 6, 1, 32'h66, 0);
        add(1, 7, 2, 32'h77, 1);
        run_idle(50);
        rr_mode = 2;
        add(0, 999, 0, 0, 0);
        add(0, 3, 1, 0, 0);
        add(0, 4, 2, 0, 0);
        repeat (3) tick();
        #2 rst_n = 0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_rsp_idx", 32'(rsp_idx), 0);
        chk("arst_rsp_err", 32'(rsp_err), 0);
        chk("arst_req_ready", 32'(req_ready), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err), 0);
        q.delete();
        reqs.delete();
        draining = 0;
        exp_done = 0;
        exp_err  = 0;
        fresh    = 1;
        @(negedge clk);
        rst_n   = 1;
        rr_mode = 1;
        repeat (6) tick();
        bubbles = 1;
        for (int v = 0; v < 40; v++) begin
            int len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++)
                add(1'($urandom_range(1)), $urandom_range(7) == 0 ? 256 + $urandom_range(2000) : $urandom_range(31),
                    4'(j), $urandom, j == len - 1);
        end
        run_idle(5000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
